// File: rtl/mc_sched_ctrl.sv
// rtl/mc_sched_ctrl.sv - Monte-Carlo pricing sequencer: parameter load, Sobol warm-up, path gating, result output
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid, cmd, cmd_data        host command (0 abort, 1 param word, 2 start sobol, 3 start pricing)
//   w, q, s0, k                     registered pricing parameters
//   sobol_en, gen_en, pricing_en    registered enables decoded from state
//   gen_valid, gen_path             Path_Gen sample stream
//   pricing_resend, resend          Pricing replay request and its PRICE-gated copy
//   pricing_valid, pricing_price    Pricing result
//   out_valid, out_data             registered host result
//   day_idx, path_idx, gen_done     generation progress
//   cmd_err                         one-cycle pulse for a command illegal in the current state
module mc_sched_ctrl #(
    parameter int DW     = 12,
    parameter int DAY    = 8,
    parameter int N_PATH = 256,
    parameter int WARMUP = 2000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    input  logic [1:0]                cmd,
    input  logic [DW-1:0]             cmd_data,
    output logic [DW-1:0]             w,
    output logic [DW-1:0]             q,
    output logic [DW-1:0]             s0,
    output logic [DW-1:0]             k,
    output logic                      sobol_en,
    output logic                      gen_en,
    input  logic                      gen_valid,
    input  logic [DW-1:0]             gen_path,
    output logic                      pricing_en,
    input  logic                      pricing_resend,
    input  logic                      pricing_valid,
    input  logic [DW-1:0]             pricing_price,
    output logic                      resend,
    output logic                      out_valid,
    output logic [DW-1:0]             out_data,
    output logic [$clog2(DAY)-1:0]    day_idx,
    output logic [$clog2(N_PATH)-1:0] path_idx,
    output logic                      gen_done,
    output logic                      cmd_err
);

    localparam int DIW = $clog2(DAY);
    localparam int PIW = $clog2(N_PATH);
    localparam int WW  = $clog2(WARMUP);

    localparam logic [DIW-1:0] DAY_LAST  = DIW'(DAY - 1);
    localparam logic [PIW-1:0] PATH_LAST = PIW'(N_PATH - 1);
    localparam logic [WW-1:0]  WARM_LAST = WW'(WARMUP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PARAM,
        S_WARMUP,
        S_GEN,
        S_PRICE,
        S_DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            err_d;
    logic            sobol_en_d;
    logic            gen_en_d;
    logic            pricing_en_d;
    logic [2:0]      param_cnt;
    logic [WW-1:0]   warm_cnt;

    logic abort;
    logic param_wr;
    logic gen_beat;
    logic price_beat;

    assign abort      = cmd_valid && (cmd == 2'd0);
    assign param_wr   = cmd_valid && (cmd == 2'd1);
    assign gen_beat   = (state_q == S_GEN) && gen_valid;
    assign price_beat = (state_q == S_PRICE) && pricing_valid;

    assign resend = pricing_resend && (state_q == S_PRICE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Autonomous transitions are resolved first; a legal
    // command then overrides them and an illegal one leaves them untouched.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;

        if (state_q == S_WARMUP && warm_cnt == WARM_LAST) begin
            state_d = S_GEN;
        end
        if (price_beat) begin
            state_d = S_DONE;
        end

        if (cmd_valid) begin
            case (cmd)
                2'd0: state_d = S_IDLE;
                2'd1: begin
                    if (state_q == S_IDLE) begin
                        state_d = S_PARAM;
                    end else if (state_q != S_PARAM) begin
                        err_d = 1'b1;
                    end
                end
                2'd2: begin
                    if (state_q == S_PARAM && param_cnt == 3'd4) begin
                        state_d = S_WARMUP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    // gen_done is the registered flag, so the beat that first
                    // sets it cannot also admit a start-pricing command.
                    if (state_q == S_GEN && gen_done) begin
                        state_d = S_PRICE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // Output decode of the upcoming state; registered below so the enables
    // track the state register exactly.
    always_comb begin
        sobol_en_d   = 1'b0;
        gen_en_d     = 1'b0;
        pricing_en_d = 1'b0;
        case (state_d)
            S_WARMUP: sobol_en_d = 1'b1;
            S_GEN: begin
                sobol_en_d = 1'b1;
                gen_en_d   = 1'b1;
            end
            S_PRICE: begin
                sobol_en_d   = 1'b1;
                pricing_en_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables, error pulse and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sobol_en   <= 1'b0;
            gen_en     <= 1'b0;
            pricing_en <= 1'b0;
            cmd_err    <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            sobol_en   <= sobol_en_d;
            gen_en     <= gen_en_d;
            pricing_en <= pricing_en_d;
            cmd_err    <= err_d;
            out_valid  <= gen_beat || price_beat;
            if (gen_beat) begin
                out_data <= gen_path;
            end else if (price_beat) begin
                out_data <= pricing_price;
            end
        end
    end

    // Parameter registers; survive an abort, only reset clears them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w         <= '0;
            q         <= '0;
            s0        <= '0;
            k         <= '0;
            param_cnt <= '0;
        end else if (abort) begin
            param_cnt <= '0;
        end else if (param_wr && state_q == S_IDLE) begin
            w         <= cmd_data;
            param_cnt <= 3'd1;
        end else if (param_wr && state_q == S_PARAM && param_cnt < 3'd4) begin
            case (param_cnt)
                3'd0:    w  <= cmd_data;
                3'd1:    q  <= cmd_data;
                3'd2:    s0 <= cmd_data;
                default: k  <= cmd_data;
            endcase
            param_cnt <= param_cnt + 3'd1;
        end
    end

    // Warm-up counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt <= '0;
        end else if (abort || state_q != S_WARMUP) begin
            warm_cnt <= '0;
        end else begin
            warm_cnt <= warm_cnt + WW'(1);
        end
    end

    // Day / path counters and the sticky generation-complete flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day_idx  <= '0;
            path_idx <= '0;
            gen_done <= 1'b0;
        end else if (abort || (state_q == S_WARMUP && state_d == S_GEN)) begin
            day_idx  <= '0;
            path_idx <= '0;
            gen_done <= 1'b0;
        end else if (gen_beat) begin
            if (day_idx == DAY_LAST) begin
                day_idx <= '0;
                if (path_idx == PATH_LAST) begin
                    path_idx <= '0;
                    gen_done <= 1'b1;
                end else begin
                    path_idx <= path_idx + PIW'(1);
                end
            end else begin
                day_idx <= day_idx + DIW'(1);
            end
        end
    end

endmodule
